// File: rtl/bus_mem_responder.sv
// Tagged fixed-latency memory responder with 15 outstanding load tags.
// Optional MEM_STORE_ACK_EN: stores are tagged and acknowledged like loads.
module bus_mem_responder #(
  parameter int MEM_LATENCY = 20,
  parameter int MEM_WORDS   = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

`ifdef MEM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  logic [63:0] mem [MEM_WORDS];

  logic [15:1] busy_q, busy_d;
  logic [4:0]  cnt_q  [15:1];
  logic [4:0]  cnt_d  [15:1];
  logic [63:0] slot_q [15:1];
  logic [63:0] slot_d [15:1];

  logic          is_load, is_store;
  logic          in_range, tag_req, grant, wr_en;
  logic [3:0]    free_tag, ret_tag;
  logic [63:0]   ret_data;
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign unused_addr = ^proc2mem_addr[2:0];
  assign idx      = proc2mem_addr[AW+2:3];
  assign in_range = proc2mem_addr[63:3] < 61'(MEM_WORDS);
  assign is_load  = proc2mem_command == BUS_LOAD;
  assign is_store = proc2mem_command == BUS_STORE;
  assign tag_req  = is_load || (STORE_ACK && is_store);

  always_comb begin
    free_tag = 4'd0;
    for (int i = 15; i >= 1; i--) begin
      if (!busy_q[i]) free_tag = 4'(i);
    end
    grant = reset && tag_req && in_range && (free_tag != 4'd0);
    wr_en = reset && is_store && in_range && (!STORE_ACK || grant);
  end

  // Fixed latency and one grant per cycle mean at most one slot expires.
  always_comb begin
    ret_tag  = 4'd0;
    ret_data = 64'd0;
    for (int i = 1; i <= 15; i++) begin
      if (busy_q[i] && cnt_q[i] == 5'd1) begin
        ret_tag  = 4'(i);
        ret_data = slot_q[i];
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    slot_d = slot_q;
    for (int i = 1; i <= 15; i++) begin
      if (busy_q[i]) begin
        cnt_d[i] = cnt_q[i] - 5'd1;
        if (cnt_q[i] == 5'd1) busy_d[i] = 1'b0;
      end
    end
    if (grant) begin
      busy_d[free_tag] = 1'b1;
      cnt_d[free_tag]  = 5'(MEM_LATENCY);
      slot_d[free_tag] = is_load ? mem[idx] : 64'd0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
      for (int i = 1; i <= 15; i++) begin
        cnt_q[i]  <= 5'd0;
        slot_q[i] <= 64'd0;
      end
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      slot_q <= slot_d;
    end
  end

  // Backing storage is deliberately outside the reset domain.
  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= proc2mem_data;
  end

  assign mem2proc_response = grant ? free_tag : 4'd0;
  assign mem2proc_tag      = reset ? ret_tag  : 4'd0;
  assign mem2proc_data     = reset ? ret_data : 64'd0;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench: latency-4 instance for vector table and corner cases,
// latency-20 instance for tag exhaustion.
module tb_bus_mem_responder;

  localparam int W = 256;
`ifdef MEM_STORE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd = 2'd0, cmd20 = 2'd0;
  logic [63:0] addr = '0, wd = '0, addr20 = '0, wd20 = '0;
  logic [3:0]  resp, tag, resp20, tag20;
  logic [63:0] rdata, rdata20;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_mem_responder #(.MEM_LATENCY(4), .MEM_WORDS(W)) u4 (
    .clock(clk), .reset(rst_n),
    .proc2mem_command(cmd), .proc2mem_addr(addr),
    .proc2mem_data(wd), .mem2proc_response(resp),
    .mem2proc_data(rdata), .mem2proc_tag(tag)
  );

  bus_mem_responder #(.MEM_LATENCY(20), .MEM_WORDS(W)) u20 (
    .clock(clk), .reset(rst_n),
    .proc2mem_command(cmd20), .proc2mem_addr(addr20),
    .proc2mem_data(wd20), .mem2proc_response(resp20),
    .mem2proc_data(rdata20), .mem2proc_tag(tag20)
  );

  typedef struct {
    logic [1:0]  cmd;
    logic [63:0] addr;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [63:0] data;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] c, input logic [63:0] a,
                     input logic [63:0] d);
    tick();
    cmd = c; addr = a; wd = d;
    @(negedge clk);
  endtask

  task automatic chk_out(input string nm, input logic [3:0] r,
                         input logic [3:0] t, input logic [63:0] d);
    chk({nm, ".resp"}, 64'(resp), 64'(r));
    chk({nm, ".tag"}, 64'(tag), 64'(t));
    chk({nm, ".data"}, rdata, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(2'd0, 64'd0, 64'd0);
  endtask

  localparam logic [63:0] A0 = 64'hA0A0_0000_0000_0001;
  localparam logic [63:0] A1 = 64'hA1A1_0000_0000_0002;
  localparam logic [63:0] A2 = 64'hA2A2_0000_0000_0003;
  localparam logic [63:0] A3 = 64'hA3A3_0000_0000_0004;
  localparam logic [63:0] OOR = 64'(W * 8);

  initial begin
    vt[0]  = '{2'd1, 64'h00,  4'd1, 4'd0, 64'd0};
    vt[1]  = '{2'd1, 64'h08,  4'd2, 4'd0, 64'd0};
    vt[2]  = '{2'd1, 64'h10,  4'd3, 4'd0, 64'd0};
    vt[3]  = '{2'd1, 64'h18,  4'd4, 4'd0, 64'd0};
    vt[4]  = '{2'd1, 64'h00,  4'd5, 4'd1, A0};
    vt[5]  = '{2'd1, 64'h0F,  4'd1, 4'd2, A1};
    vt[6]  = '{2'd1, OOR,     4'd0, 4'd3, A2};
    vt[7]  = '{2'd3, 64'h00,  4'd0, 4'd4, A3};
    vt[8]  = '{2'd0, 64'h00,  4'd0, 4'd5, A0};
    vt[9]  = '{2'd0, 64'h00,  4'd0, 4'd1, A1};
    vt[10] = '{2'd0, 64'h00,  4'd0, 4'd0, 64'd0};

    // reset state, with a load presented
    cmd = 2'd1; cmd20 = 2'd1;
    #3;
    chk_out("rst", 4'd0, 4'd0, 64'd0);
    chk("rst.resp20", 64'(resp20), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    cmd = 2'd0; cmd20 = 2'd0;

    // prefill storage, then let any acked store tags drain
    drv(2'd2, 64'h00, A0);
    drv(2'd2, 64'h08, A1);
    drv(2'd2, 64'h10, A2);
    drv(2'd2, 64'h18, A3);
    idle(6);

    for (int i = 0; i < 11; i++) begin
      drv(vt[i].cmd, vt[i].addr, 64'd0);
      chk_out($sformatf("vec%0d", i), vt[i].resp, vt[i].tag, vt[i].data);
    end

    // store then load ten cycles later: single return at +4
    drv(2'd2, 64'h40, 64'h1122_3344_5566_7788);
    chk("st40.resp", 64'(resp), ACK ? 64'd1 : 64'd0);
    idle(9);
    drv(2'd1, 64'h40, 64'd0);
    chk_out("ld40", 4'd1, 4'd0, 64'd0);
    for (int i = 1; i <= 5; i++) begin
      drv(2'd0, 64'd0, 64'd0);
      if (i == 4)
        chk_out("ld40.ret", 4'd0, 4'd1, 64'h1122_3344_5566_7788);
      else
        chk_out($sformatf("ld40.q%0d", i), 4'd0, 4'd0, 64'd0);
    end

    // snapshot isolation against a later store
    drv(2'd2, 64'h80, 64'h5A);
    idle(6);
    drv(2'd1, 64'h80, 64'd0);
    chk("snap.r0", 64'(resp), 64'd1);
    drv(2'd2, 64'h80, 64'hFF);
    chk("snap.r1", 64'(resp), ACK ? 64'd2 : 64'd0);
    drv(2'd1, 64'h80, 64'd0);
    chk("snap.r2", 64'(resp), ACK ? 64'd3 : 64'd2);
    drv(2'd0, 64'd0, 64'd0);
    drv(2'd0, 64'd0, 64'd0);
    chk_out("snap.old", 4'd0, 4'd1, 64'h5A);
    drv(2'd0, 64'd0, 64'd0);
    chk_out("snap.c5", 4'd0, ACK ? 4'd2 : 4'd0, 64'd0);
    drv(2'd0, 64'd0, 64'd0);
    chk_out("snap.new", 4'd0, ACK ? 4'd3 : 4'd2, 64'hFF);
    idle(2);

    // reset with loads in flight
    drv(2'd1, 64'h00, 64'd0);
    chk("rf.r0", 64'(resp), 64'd1);
    drv(2'd1, 64'h08, 64'd0);
    chk("rf.r1", 64'(resp), 64'd2);
    tick();
    rst_n = 1'b0;
    cmd = 2'd1; addr = 64'h00;
    #1;
    chk_out("rf.low", 4'd0, 4'd0, 64'd0);
    tick();
    cmd = 2'd0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drv(2'd0, 64'd0, 64'd0);
      chk_out($sformatf("rf.q%0d", i), 4'd0, 4'd0, 64'd0);
    end
    drv(2'd1, 64'h00, 64'd0);
    chk("rf.next", 64'(resp), 64'd1);
    idle(5);

    // out-of-range store and store tagging
    drv(2'd2, OOR, 64'h77);
    chk("oorst.resp", 64'(resp), 64'd0);
    idle(5);
    drv(2'd2, 64'h00, 64'h99);
    chk("st0.resp", 64'(resp), ACK ? 64'd1 : 64'd0);
    idle(3);
    drv(2'd0, 64'd0, 64'd0);
    chk_out("st0.ret", 4'd0, ACK ? 4'd1 : 4'd0, 64'd0);
    drv(2'd1, 64'h00, 64'd0);
    chk("st0.ld", 64'(resp), 64'd1);
    idle(3);
    drv(2'd0, 64'd0, 64'd0);
    chk_out("st0.data", 4'd0, 4'd1, 64'h99);

    // tag exhaustion on the latency-20 instance
    tick();
    cmd20 = 2'd2; addr20 = 64'h00; wd20 = 64'hC0DE;
    for (int i = 0; i < 25; i++) begin
      tick();
      cmd20 = 2'd0;
    end
    for (int c = 0; c <= 21; c++) begin
      tick();
      cmd20 = (c <= 15 || c >= 20) ? 2'd1 : 2'd0;
      addr20 = 64'h00;
      @(negedge clk);
      if (c <= 15)
        chk($sformatf("ex.r%0d", c), 64'(resp20), c == 15 ? 64'd0 : 64'(c + 1));
      if (c == 20) begin
        chk("ex.r20", 64'(resp20), 64'd0);
        chk("ex.t20", 64'(tag20), 64'd1);
        chk("ex.d20", rdata20, 64'hC0DE);
      end
      if (c == 21) begin
        chk("ex.r21", 64'(resp20), 64'd1);
        chk("ex.t21", 64'(tag20), 64'd2);
      end
    end
    tick();
    cmd20 = 2'd0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
